keypad_scanner: RTL

- Upstream stage of password_machine: scans a 4x4 active-low matrix keypad, debounces presses and releases, and encodes the pressed key to a 4-bit code.
- Emits a one-cycle o_valid strobe per accepted press; o_digit and o_valid feed the password FSM's digit and key inputs.
- Runs on the system clock; all timing is in clock cycles.

---
 rtl/keypad_pkg.sv | 53 +++++
 rtl/keypad_scanner_if.sv | 37 +++
 rtl/keypad_debounce.sv | 42 ++++
 rtl/keypad_scanner.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, key map and row-decode helpers for keypad_scanner
//
// Contents:
//   kp_state_e  : scanner FSM states SCAN, DEBOUNCE, PRESSED, RELEASE
//   KEY_STAR    : code reported for the '*' key (4'hE)
//   KEY_HASH    : code reported for the '#' key (4'hF)
//   KEY_MAP     : 16 x 4-bit row/col-to-code table, entry (row*4+col) at bits [4*(row*4+col) +: 4]
//   key_code()  : looks up a code from a row/column index pair
//   one_low()   : true when exactly one active-low row bit is asserted
//   row_index() : index of the single low row in a one-low pattern

package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } kp_state_e;

    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    // Written most-significant entry first: row 3 down to row 0, column 3 down to column 0.
    localparam logic [63:0] KEY_MAP = {
        4'hD, KEY_HASH, 4'h0, KEY_STAR,     // row 3: *, 0, #, D
        4'hC, 4'h9,     4'h8, 4'h7,         // row 2: 7, 8, 9, C
        4'hB, 4'h6,     4'h5, 4'h4,         // row 1: 4, 5, 6, B
        4'hA, 4'h3,     4'h2, 4'h1          // row 0: 1, 2, 3, A
    };

    function automatic logic [3:0] key_code(input logic [1:0] row_idx, input logic [1:0] col_idx);
        logic [5:0] base;
        base = {row_idx, col_idx, 2'b00};
        return KEY_MAP[base +: 4];
    endfunction

    function automatic logic one_low(input logic [3:0] rows);
        return (rows == 4'b1110) || (rows == 4'b1101) ||
               (rows == 4'b1011) || (rows == 4'b0111);
    endfunction

    // Only meaningful when one_low(rows) is true; other patterns fold onto row 0.
    function automatic logic [1:0] row_index(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        if (!rows[1]) idx = 2'd1;
        if (!rows[2]) idx = 2'd2;
        if (!rows[3]) idx = 2'd3;
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - keypad matrix and key-event bundle for keypad_scanner
//
// Signals:
//   i_row   [3:0] keypad rows, active-low, asynchronous to the scanner clock
//   o_col   [3:0] column drive, one-cold
//   o_digit [3:0] code of last accepted key
//   o_valid       one-cycle strobe for a newly accepted (or repeated) key
//   o_held        high from accept until the release is debounced
// Modports:
//   master : the scanner (reads rows, drives columns and key events)
//   slave  : the keypad / consumer side

interface keypad_scanner_if;

    logic [3:0] i_row;
    logic [3:0] o_col;
    logic [3:0] o_digit;
    logic       o_valid;
    logic       o_held;

    modport master (
        input  i_row,
        output o_col,
        output o_digit,
        output o_valid,
        output o_held
    );

    modport slave (
        output i_row,
        input  o_col,
        input  o_digit,
        input  o_valid,
        input  o_held
    );

endinterface

// File: rtl/keypad_debounce.sv
// rtl/keypad_debounce.sv - stable-for-N-cycles counter
//
// Parameters:
//   N       : consecutive matching cycles required (>= 2)
// Ports:
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset
//   i_clear : forces the count to zero (owner is not debouncing)
//   i_match : the watched condition holds this cycle
//   o_done  : combinational; high on the N-th consecutive matching cycle
//
// A cycle without a match drops the count back to zero. The count stops
// at N-1 instead of wrapping, so o_done stays asserted while the match holds.

module keypad_debounce #(
    parameter int N = 500000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_match,
    output logic o_done
);

    localparam int W = (N > 1) ? $clog2(N) : 1;
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (i_clear || !i_match) begin
            cnt <= '0;
        end else if (cnt != LAST) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign o_done = i_match && !i_clear && (cnt == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with press/release debounce
//
// Parameters:
//   SCAN_DIV        : cycles each column is driven (>= 4)
//   DEBOUNCE_CYCLES : consecutive stable cycles to accept a press or a release (>= 2)
//   REPEAT_DELAY    : cycles from accept to first auto-repeat
//   REPEAT_PERIOD   : cycles between auto-repeats
// Ports:
//   i_clk   : system clock
//   i_rst_n : asynchronous active-low reset
//   kp      : keypad_scanner_if.master (i_row in; o_col, o_digit, o_valid, o_held out)
// Build option:
//   KEYPAD_AUTOREPEAT_EN : when defined, a held key re-pulses o_valid after
//                          REPEAT_DELAY and then every REPEAT_PERIOD cycles.

module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    keypad_scanner_if.master kp
);

    if (SCAN_DIV < 4) begin : g_bad_scan_div
        $error("keypad_scanner: SCAN_DIV must be at least 4");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("keypad_scanner: DEBOUNCE_CYCLES must be at least 2");
    end
    if (REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_repeat
        $error("keypad_scanner: REPEAT_DELAY and REPEAT_PERIOD must be at least 2");
    end

    localparam int SW = $clog2(SCAN_DIV);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    // ------------------------------------------------------------------
    // Row synchroniser: rows idle high, so reset to all-released.
    // ------------------------------------------------------------------
    logic [3:0] row_s1;
    logic [3:0] row_s2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            row_s1 <= 4'hF;
            row_s2 <= 4'hF;
        end else begin
            row_s1 <= kp.i_row;
            row_s2 <= row_s1;
        end
    end

    // ------------------------------------------------------------------
    // FSM and scan datapath
    // ------------------------------------------------------------------
    kp_state_e      state;
    kp_state_e      state_nxt;
    logic [1:0]     col_idx;
    logic [SW-1:0]  scan_cnt;
    logic [3:0]     cap_row;

    logic           scan_last;
    logic           capture;
    logic           col_adv;
    logic           accept;
    logic           release_done;
    logic           db_clear;
    logic           db_match;
    logic           db_done;
    logic           rep_fire;
    logic           all_high;

    assign scan_last = (scan_cnt == SCAN_LAST);
    assign all_high  = (row_s2 == 4'hF);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= SCAN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        capture      = 1'b0;
        col_adv      = 1'b0;
        accept       = 1'b0;
        release_done = 1'b0;
        db_clear     = 1'b1;
        db_match     = 1'b0;
        case (state)
            SCAN: begin
                // Rows are only trusted on the last dwell cycle of a column.
                if (scan_last) begin
                    if (one_low(row_s2)) begin
                        capture   = 1'b1;
                        // The sampling cycle counts as the first stable cycle.
                        db_clear  = 1'b0;
                        db_match  = 1'b1;
                        state_nxt = DEBOUNCE;
                    end else begin
                        col_adv = 1'b1;
                    end
                end
            end
            DEBOUNCE: begin
                db_clear = 1'b0;
                db_match = (row_s2 == cap_row);
                if (!db_match) begin
                    col_adv   = 1'b1;
                    state_nxt = SCAN;
                end else if (db_done) begin
                    accept    = 1'b1;
                    state_nxt = PRESSED;
                end
            end
            PRESSED: begin
                // Counting starts with the first all-high cycle seen here so
                // that release takes exactly DEBOUNCE_CYCLES stable cycles.
                db_clear = 1'b0;
                db_match = all_high;
                if (all_high) begin
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                db_clear = 1'b0;
                db_match = all_high;
                if (!all_high) begin
                    state_nxt = PRESSED;
                end else if (db_done) begin
                    release_done = 1'b1;
                    col_adv      = 1'b1;
                    state_nxt    = SCAN;
                end
            end
            default: begin
                state_nxt = SCAN;
            end
        endcase
    end

    keypad_debounce #(
        .N (DEBOUNCE_CYCLES)
    ) u_debounce (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clear (db_clear),
        .i_match (db_match),
        .o_done  (db_done)
    );

    // Column position is frozen outside SCAN; leaving DEBOUNCE or RELEASE
    // back to SCAN always moves on to the next column.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            col_idx  <= 2'd0;
            scan_cnt <= '0;
            cap_row  <= 4'hF;
        end else begin
            if (col_adv) begin
                col_idx  <= col_idx + 2'd1;
                scan_cnt <= '0;
            end else if (state == SCAN && !scan_last) begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            if (capture) begin
                cap_row <= row_s2;
            end
        end
    end

    assign kp.o_col = ~(4'b0001 << col_idx);

    // ------------------------------------------------------------------
    // Auto-repeat
    // ------------------------------------------------------------------
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX);
    localparam logic [RW-1:0] REP_FIRST_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] REP_NEXT_LAST  = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rep_cnt;
    logic          rep_first;
    logic          rep_hold;

    // Cycle 0 of rep_cnt is the cycle o_valid is high for the accept.
    assign rep_hold = (state == PRESSED) && (state_nxt == PRESSED);
    assign rep_fire = rep_hold &&
                      (rep_cnt == (rep_first ? REP_FIRST_LAST : REP_NEXT_LAST));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rep_cnt   <= '0;
            rep_first <= 1'b1;
        end else if (!rep_hold) begin
            // Any glitch toward release restarts the initial delay.
            rep_cnt   <= '0;
            rep_first <= 1'b1;
        end else if (rep_fire) begin
            rep_cnt   <= '0;
            rep_first <= 1'b0;
        end else begin
            rep_cnt <= rep_cnt + 1'b1;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Registered key-event outputs
    // ------------------------------------------------------------------
    logic [3:0] digit_q;
    logic       valid_q;
    logic       held_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            digit_q <= 4'h0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            valid_q <= accept || rep_fire;
            if (accept) begin
                digit_q <= key_code(row_index(cap_row), col_idx);
                held_q  <= 1'b1;
            end else if (release_done) begin
                held_q  <= 1'b0;
            end
        end
    end

    assign kp.o_digit = digit_q;
    assign kp.o_valid = valid_q;
    assign kp.o_held  = held_q;

endmodule
